// File: rtl/regfile_wb_scheduler.sv
// Write-side scheduler: steers up to two writebacks per cycle into even/odd bank FIFOs
// and drains one write per bank per cycle. Optional REGFILE_WB_PENDING_EN adds pending_o.
module regfile_wb_scheduler #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb0_valid_i,
    output logic             wb0_ready_o,
    input  logic [4:0]       wb0_addr_i,
    input  logic [WIDTH-1:0] wb0_data_i,
    input  logic             wb1_valid_i,
    output logic             wb1_ready_o,
    input  logic [4:0]       wb1_addr_i,
    input  logic [WIDTH-1:0] wb1_data_i,
    output logic [4:0]       wa0_o,
    output logic [WIDTH-1:0] wd0_o,
    output logic             we0_o,
    output logic [4:0]       wa1_o,
    output logic [WIDTH-1:0] wd1_o,
    output logic             we1_o,
`ifdef REGFILE_WB_PENDING_EN
    output logic [31:0]      pending_o,
`endif
    output logic             idle_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [4:0]       addr_q [2][DEPTH];
    logic [4:0]       addr_d [2][DEPTH];
    logic [WIDTH-1:0] data_q [2][DEPTH];
    logic [WIDTH-1:0] data_d [2][DEPTH];
    logic [CW-1:0]    cnt_q  [2];
    logic [CW-1:0]    cnt_d  [2];
    logic [PW-1:0]    rd_q   [2];
    logic [PW-1:0]    rd_d   [2];
    logic [PW-1:0]    wr_q   [2];
    logic [PW-1:0]    wr_d   [2];
    logic [SW-1:0]    space  [2];

    logic          push0, push1, pop, bank;
    logic [PW-1:0] wp;
    logic [1:0]    npush;

    always_comb begin
        space = '{default: '0};
        for (int unsigned b = 0; b < 2; b++) begin
            space[1'(b)] = SW'(DEPTH) - SW'(cnt_q[1'(b)]) + SW'(cnt_q[1'(b)] != '0);
        end
    end

    assign wb0_ready_o = (space[0] >= SW'(1)) && (space[1] >= SW'(1));
    assign wb1_ready_o = (space[0] >= SW'(2)) && (space[1] >= SW'(2));

    // Register 0 writes finish the handshake but never occupy a FIFO slot.
    assign push0 = wb0_valid_i && wb0_ready_o && (wb0_addr_i != 5'd0);
    assign push1 = wb1_valid_i && wb1_ready_o && (wb1_addr_i != 5'd0);

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        wp     = '0;
        npush  = '0;
        pop    = 1'b0;
        bank   = 1'b0;
        for (int unsigned b = 0; b < 2; b++) begin
            bank  = 1'(b);
            wp    = wr_q[bank];
            npush = '0;
            // Channel 0 is older, so it takes the first free slot of a shared bank.
            if (push0 && (wb0_addr_i[0] == bank)) begin
                addr_d[bank][wp] = wb0_addr_i;
                data_d[bank][wp] = wb0_data_i;
                wp    = wp + PW'(1);
                npush = npush + 2'd1;
            end
            if (push1 && (wb1_addr_i[0] == bank)) begin
                addr_d[bank][wp] = wb1_addr_i;
                data_d[bank][wp] = wb1_data_i;
                wp    = wp + PW'(1);
                npush = npush + 2'd1;
            end
            pop         = (cnt_q[bank] != '0);
            wr_d[bank]  = wp;
            rd_d[bank]  = rd_q[bank] + PW'(pop);
            cnt_d[bank] = cnt_q[bank] + CW'(npush) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '{default: '0};
            data_q <= '{default: '0};
            cnt_q  <= '{default: '0};
            rd_q   <= '{default: '0};
            wr_q   <= '{default: '0};
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
        end
    end

    assign we0_o  = (cnt_q[0] != '0);
    assign wa0_o  = addr_q[0][rd_q[0]];
    assign wd0_o  = data_q[0][rd_q[0]];
    assign we1_o  = (cnt_q[1] != '0);
    assign wa1_o  = addr_q[1][rd_q[1]];
    assign wd1_o  = data_q[1][rd_q[1]];
    assign idle_o = (cnt_q[0] == '0) && (cnt_q[1] == '0);

`ifdef REGFILE_WB_PENDING_EN
    logic [PW-1:0] off;

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        pending_o = '0;
        off       = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                off = PW'(i) - rd_q[1'(b)];
                if (CW'(off) < cnt_q[1'(b)]) begin
                    pending_o[addr_q[1'(b)][PW'(i)]] = 1'b1;
                end
            end
        end
        pending_o[0] = 1'b0;
    end
`endif

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-side scheduler for the 32-entry, 2-bank (even/odd address) 4-read/2-write register file. It accepts up to two writeback requests per cycle from the execution pipes, steers each into a per-bank FIFO by `addr[0]`, and drains at most one write per bank per cycle. Bank conflicts therefore never reach the register file. It sits between the writeback stage and the register file's `wa*/wd*/we*` ports.

## Interface
- `WIDTH`, default 32: data width.
- `DEPTH`, default 2: entries per bank FIFO. Power of two, range 2..8.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `wb0_valid_i` in 1: channel 0 request. Channel 0 is older in program order.
- `wb0_ready_o` out 1: channel 0 accept.
- `wb0_addr_i` in 5: channel 0 destination register.
- `wb0_data_i` in WIDTH: channel 0 data.
- `wb1_valid_i`, `wb1_ready_o`, `wb1_addr_i`, `wb1_data_i`: channel 1, same widths. Channel 1 is younger.
- `wa0_o` out 5, `wd0_o` out WIDTH, `we0_o` out 1: register-file port 0, driven only by the even-bank FIFO head.
- `wa1_o` out 5, `wd1_o` out WIDTH, `we1_o` out 1: register-file port 1, driven only by the odd-bank FIFO head.
- `idle_o` out 1: both FIFOs empty.
- `pending_o` out 32: per-register pending-write bitmap. Present only with `REGFILE_WB_PENDING_EN`.

## Operation
- Handshake: a request transfers when `valid && ready` at a rising edge.
  - Data and addr must be held stable while valid is high and ready is low.
  - Ready does not depend on the same channel's valid or addr.
- Bank select is `addr[0]`: 0 selects bank E (even), 1 selects bank O (odd).
- Per-bank state is a FIFO with count `cnt_E` / `cnt_O` (0..DEPTH).
- Every cycle a non-empty FIFO pops its head. The register file applies no backpressure.
- Space per bank: `space = DEPTH - cnt + (cnt != 0)`.
- `wb0_ready_o = (space_E >= 1) && (space_O >= 1)`.
- `wb1_ready_o = (space_E >= 2) && (space_O >= 2)`.
- Same-cycle transfers to the same bank:
  - Channel 0 is enqueued first, then channel 1.
  - Same-address pairs therefore leave channel 1's value as final.
- Transfers with addr == 0 complete the handshake but are discarded. Nothing is enqueued.
- Port outputs:
  - `we0_o = (cnt_E != 0)`, `wa0_o`/`wd0_o` = E head.
  - `we1_o = (cnt_O != 0)`, `wa1_o`/`wd1_o` = O head.
  - When `we*_o` is 0, addr/data hold their last values (don't-care).
- Guarantees:
  - `wa0_o[0]` = 0 whenever `we0_o` = 1.
  - `wa1_o[0]` = 1 whenever `we1_o` = 1.
  - The register file's conflict indication is never true with both enables high.
  - Order is preserved per bank. Since a register maps to exactly one bank, per-register write order is preserved.
- Counts saturate by construction; overflow is impossible given the ready equations.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async, `rst_n` low) clears counts and pointers.
  - Outputs during reset: `we0_o` = `we1_o` = 0, `wa*_o` = 0, `wd*_o` = 0, `idle_o` = 1, `pending_o` = 0.
  - Readies come out of reset high (DEPTH >= 2).
- Reset mid-operation discards all queued writes; none is issued after reset.
- Latency:
  - A request accepted at edge N with an empty target FIFO drives `we*_o` during cycle N+1.
  - The register file commits it at edge N+2.
- Sustained throughput: one write per bank per cycle. Alternating-bank pairs stream at 2 writes/cycle with `DEPTH` = 2.
- Simultaneous push and pop on one FIFO in the same cycle: `cnt` changes by `pushes - 1`.
- `idle_o` is combinational from registered counts.

## Configuration
- `REGFILE_WB_PENDING_EN` defined:
  - `pending_o[r]` = 1 when any valid FIFO entry in either bank has addr r. Combinational from FIFO state.
  - Issue logic uses it for RAW interlock.
  - `pending_o[0]` is always 0.
- Not defined: the `pending_o` port and its logic are absent.

## Test plan
- Reset, then ch0 writes r4=0x11 and ch1 writes r7=0x22 in the same cycle -> next cycle `we0_o`=1/`wa0_o`=4/`wd0_o`=0x11 and `we1_o`=1/`wa1_o`=7/`wd1_o`=0x22. Both readies stay 1.
- ch0 r2=0xA and ch1 r6=0xB in the same cycle -> cycle N+1 port 0 writes r2, cycle N+2 port 0 writes r6. Port 1 idle. `wb1_ready_o` drops to 0 for cycle N+1.
- ch0 r8=0x1 and ch1 r8=0x2 in the same cycle -> r8 written 0x1 then 0x2 on consecutive cycles. With the macro, `pending_o[8]` is high for 2 cycles.
- Both channels write r0 -> handshakes complete; `we0_o`, `we1_o` stay 0; `idle_o` stays 1.
- Back-to-back even-bank-only traffic on both channels for 10 cycles -> no lost writes, per-channel order preserved, and `wa0_o[0]`=0 on every `we0_o` cycle.
- Assert `rst_n` low with 2 entries queued -> `we*_o` 0 immediately (async), `idle_o`=1, no writes after release.
